// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive path.
// Consumed by the synchronizer and the deserializer.
package uart_pkg;

    localparam int   UART_DATA_BITS          = 8;
    localparam int   UART_OVERSAMPLE_DEFAULT = 16;
    localparam logic UART_IDLE_LEVEL         = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Presets to the idle line level so reset never looks like a start bit.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= {2{UART_IDLE_LEVEL}};
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    assign rx_s = sync_reg[1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: start validation, mid-bit sampling, 8N(parity)1 framing.
// Emits dout/rxin with a one-cycle load strobe, or a framing_error pulse.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
)
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      baud_tick,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] dout,
    output logic                      rxin,
    output logic                      load,
    output logic                      framing_error,
    output logic                      busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_s  (rx_s)
    );

    uart_rx_state_e              state_reg, state_next;
    logic [TW-1:0]               tcnt_reg, tcnt_next;
    logic [BW-1:0]               bcnt_reg, bcnt_next;
    logic [UART_DATA_BITS-1:0]   shift_reg, shift_next;
    logic                        par_reg, par_next;
    logic [UART_DATA_BITS-1:0]   dout_reg, dout_next;
    logic                        rxin_reg, rxin_next;
    logic                        load_reg, load_next;
    logic                        fe_reg, fe_next;
    logic                        wrap;

    assign wrap = (tcnt_reg == T_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            tcnt_reg  <= '0;
            bcnt_reg  <= '0;
            shift_reg <= '0;
            par_reg   <= 1'b0;
            dout_reg  <= '0;
            rxin_reg  <= 1'b0;
            load_reg  <= 1'b0;
            fe_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            tcnt_reg  <= tcnt_next;
            bcnt_reg  <= bcnt_next;
            shift_reg <= shift_next;
            par_reg   <= par_next;
            dout_reg  <= dout_next;
            rxin_reg  <= rxin_next;
            load_reg  <= load_next;
            fe_reg    <= fe_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tcnt_next  = tcnt_reg;
        bcnt_next  = bcnt_reg;
        shift_next = shift_reg;
        par_next   = par_reg;
        dout_next  = dout_reg;
        rxin_next  = rxin_reg;
        load_next  = 1'b0;
        fe_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (baud_tick && !rx_s) begin
                    tcnt_next  = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                // Confirm half a bit after detection; a high line here was a glitch.
                if (baud_tick) begin
                    if (tcnt_reg == T_HALF) begin
                        tcnt_next = '0;
                        if (!rx_s) begin
                            bcnt_next  = '0;
                            state_next = ST_DATA;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        tcnt_next = tcnt_reg + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (wrap) begin
                        tcnt_next  = '0;
                        shift_next = {rx_s, shift_reg[UART_DATA_BITS-1:1]};
                        bcnt_next  = bcnt_reg + 1'b1;
                        if (bcnt_reg == B_LAST) begin
                            state_next = ST_PARITY;
                        end
                    end else begin
                        tcnt_next = tcnt_reg + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    if (wrap) begin
                        tcnt_next  = '0;
                        par_next   = rx_s;
                        state_next = ST_STOP;
                    end else begin
                        tcnt_next = tcnt_reg + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                // Back to IDLE at mid-stop so a following start edge is not missed.
                if (baud_tick) begin
                    if (wrap) begin
                        tcnt_next = '0;
                        if (rx_s) begin
                            dout_next  = shift_reg;
                            rxin_next  = par_reg;
                            load_next  = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            fe_next    = 1'b1;
                            state_next = ST_BREAK;
                        end
                    end else begin
                        tcnt_next = tcnt_reg + 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign dout          = dout_reg;
    assign rxin          = rxin_reg;
    assign load          = load_reg;
    assign framing_error = fe_reg;
    assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed scenarios plus
// randomized frames checked against a frame-level reference model.
module tb_uart_rx_deserializer;

    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_tick;
    logic       rx;
    logic [7:0] dout;
    logic       rxin;
    logic       load;
    logic       framing_error;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         cyc_at;
    } rx_ev_t;

    rx_ev_t loads[$];
    rx_ev_t mon_ev;
    int     fe_seen   = 0;
    int     both_seen = 0;
    logic   busy_mid;

    uart_rx_deserializer #(.OVERSAMPLE(OS)) dut (
        .clk           (clk),
        .reset         (reset),
        .baud_tick     (baud_tick),
        .rx            (rx),
        .dout          (dout),
        .rxin          (rxin),
        .load          (load),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        baud_tick = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (load) begin
            mon_ev.data   = dout;
            mon_ev.par    = rxin;
            mon_ev.cyc_at = cyc;
            loads.push_back(mon_ev);
            $display("load: dout=%h rxin=%0d cycle=%0d", dout, rxin, cyc);
        end
        if (framing_error) begin
            fe_seen++;
            $display("framing_error pulse at cycle=%0d", cyc);
        end
        if (load && framing_error) both_seen++;
    end

    function automatic logic odd_ones(input logic [7:0] d);
        int n = 0;
        for (int i = 0; i < 8; i++) if (d[i]) n++;
        return (n % 2) == 1;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
            if (i == 3) busy_mid = busy;
        end
        send_bit(p);
        send_bit(s);
    endtask

    task automatic clear_mon();
        loads.delete();
        fe_seen = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx    = 1'b1;
        idle(3);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
        checks++; if (rxin !== 1'b0) begin errors++; $display("FAIL reset_rxin: got %b expected 0", rxin); end
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", load); end
        checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b expected 0", framing_error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b1;
        idle(10);
    endtask

    task automatic test_basic();
        clear_mon();
        send_frame(8'h55, 1'b0, 1'b1);
        idle(8);
        checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL basic_busy_mid: got %b expected 1", busy_mid); end
        checks++; if (loads.size() != 1) begin errors++; $display("FAIL basic_load_count: got %0d expected 1", loads.size()); end
        if (loads.size() >= 1) begin
            checks++; if (loads[0].data !== 8'h55) begin errors++; $display("FAIL basic_dout: got %h expected 55", loads[0].data); end
            checks++; if (loads[0].par !== 1'b0) begin errors++; $display("FAIL basic_rxin: got %b expected 0", loads[0].par); end
        end
        checks++; if (fe_seen != 0) begin errors++; $display("FAIL basic_fe: got %0d expected 0", fe_seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_parity_forward();
        logic [7:0] d;
        logic       sent_par[2];
        logic       flag_exp, flag_obs;
        d = 8'hA7;
        sent_par[0] = 1'b1;
        sent_par[1] = 1'b0;
        clear_mon();
        send_frame(d, sent_par[0], 1'b1);
        send_frame(d, sent_par[1], 1'b1);
        idle(8);
        checks++; if (loads.size() != 2) begin errors++; $display("FAIL parity_load_count: got %0d expected 2", loads.size()); end
        for (int i = 0; i < 2; i++) begin
            if (loads.size() > i) begin
                flag_exp = odd_ones(d) != sent_par[i];
                flag_obs = odd_ones(loads[i].data) != loads[i].par;
                checks++; if (loads[i].data !== d) begin errors++; $display("FAIL parity_dout[%0d]: got %h expected %h", i, loads[i].data, d); end
                checks++; if (loads[i].par !== sent_par[i]) begin errors++; $display("FAIL parity_rxin[%0d]: got %b expected %b", i, loads[i].par, sent_par[i]); end
                checks++; if (flag_obs !== flag_exp) begin errors++; $display("FAIL parity_downstream_flag[%0d]: got %b expected %b", i, flag_obs, flag_exp); end
            end
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx = 1'b0;
        idle(3 * TICK_DIV);
        rx = 1'b1;
        idle(8);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_in_start: got %b expected 1", busy); end
        idle(100);
        checks++; if (loads.size() != 0) begin errors++; $display("FAIL glitch_load: got %0d expected 0", loads.size()); end
        checks++; if (fe_seen != 0) begin errors++; $display("FAIL glitch_fe: got %0d expected 0", fe_seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_framing();
        clear_mon();
        send_frame(8'h55, odd_ones(8'h55), 1'b1);
        send_frame(8'h3C, odd_ones(8'h3C), 1'b0);
        idle(100);
        checks++; if (fe_seen != 1) begin errors++; $display("FAIL framing_fe_count: got %0d expected 1", fe_seen); end
        checks++; if (loads.size() != 1) begin errors++; $display("FAIL framing_load_count: got %0d expected 1", loads.size()); end
        checks++; if (dout !== 8'h55) begin errors++; $display("FAIL framing_dout_kept: got %h expected 55", dout); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL framing_busy_break: got %b expected 1", busy); end
        rx = 1'b1;
        idle(10);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL framing_busy_release: got %b expected 0", busy); end
        send_frame(8'h12, odd_ones(8'h12), 1'b1);
        idle(8);
        checks++; if (loads.size() != 2) begin errors++; $display("FAIL framing_next_load_count: got %0d expected 2", loads.size()); end
        checks++; if (dout !== 8'h12) begin errors++; $display("FAIL framing_next_dout: got %h expected 12", dout); end
        checks++; if (rxin !== odd_ones(8'h12)) begin errors++; $display("FAIL framing_next_rxin: got %b expected %b", rxin, odd_ones(8'h12)); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'h5A;
        clear_mon();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx = d[4];
        idle(BIT_CLKS / 2);
        reset = 1'b0;
        #1;
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL midreset_dout: got %h expected 00", dout); end
        checks++; if (rxin !== 1'b0) begin errors++; $display("FAIL midreset_rxin: got %b expected 0", rxin); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (load !== 1'b0 || framing_error !== 1'b0) begin errors++; $display("FAIL midreset_strobes: got load=%b fe=%b expected 0/0", load, framing_error); end
        rx = 1'b1;
        idle(4);
        reset = 1'b1;
        idle(2 * BIT_CLKS);
        checks++; if (loads.size() != 0 || fe_seen != 0) begin errors++; $display("FAIL midreset_discard: got loads=%0d fe=%0d expected 0/0", loads.size(), fe_seen); end
        send_frame(8'h81, odd_ones(8'h81), 1'b1);
        idle(8);
        checks++; if (loads.size() != 1) begin errors++; $display("FAIL midreset_next_count: got %0d expected 1", loads.size()); end
        checks++; if (dout !== 8'h81 || rxin !== 1'b0) begin errors++; $display("FAIL midreset_next_data: got %h/%b expected 81/0", dout, rxin); end
    endtask

    task automatic test_back_to_back();
        int gap;
        clear_mon();
        send_frame(8'h00, odd_ones(8'h00), 1'b1);
        send_frame(8'hFF, odd_ones(8'hFF), 1'b1);
        idle(8);
        checks++; if (loads.size() != 2) begin errors++; $display("FAIL b2b_load_count: got %0d expected 2", loads.size()); end
        if (loads.size() == 2) begin
            gap = loads[1].cyc_at - loads[0].cyc_at;
            checks++; if (loads[0].data !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h expected 00", loads[0].data); end
            checks++; if (loads[1].data !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h expected ff", loads[1].data); end
            checks++; if (loads[1].par !== 1'b0) begin errors++; $display("FAIL b2b_second_rxin: got %b expected 0", loads[1].par); end
            checks++; if (gap != 11 * BIT_CLKS) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", gap, 11 * BIT_CLKS); end
        end
    endtask

    task automatic test_random();
        rx_ev_t     exp_q[$];
        rx_ev_t     ev;
        int         fe_exp;
        logic [7:0] d;
        logic       p, s;
        fe_exp = 0;
        clear_mon();
        for (int n = 0; n < 8; n++) begin
            d = 8'($urandom_range(0, 255));
            p = odd_ones(d) ^ ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 4) != 0);
            send_frame(d, p, s);
            if (s) begin
                ev.data = d; ev.par = p; ev.cyc_at = 0;
                exp_q.push_back(ev);
                idle($urandom_range(0, 40));
            end else begin
                fe_exp++;
                rx = 1'b1;
                idle(8 + $urandom_range(0, 40));
            end
        end
        idle(8);
        checks++; if (loads.size() != exp_q.size()) begin errors++; $display("FAIL rand_load_count: got %0d expected %0d", loads.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (loads.size() > i) begin
                checks++;
                if (loads[i].data !== exp_q[i].data || loads[i].par !== exp_q[i].par) begin
                    errors++;
                    $display("FAIL rand_frame[%0d]: got %h/%b expected %h/%b", i, loads[i].data, loads[i].par, exp_q[i].data, exp_q[i].par);
                end
            end
        end
        checks++; if (fe_seen != fe_exp) begin errors++; $display("FAIL rand_fe_count: got %0d expected %0d", fe_seen, fe_exp); end
        checks++; if (both_seen != 0) begin errors++; $display("FAIL load_fe_overlap: got %0d expected 0", both_seen); end
    endtask

    initial begin
        reset = 1'b0;
        rx    = 1'b1;
        test_reset();
        test_basic();
        test_parity_forward();
        test_glitch();
        test_framing();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

UART receive front end. Takes the raw serial line, detects and validates the start bit, and samples each bit at mid-bit using a 16x oversampling baud tick. It shifts in 8 data bits (LSB first), captures the parity bit and checks the stop bit. It sits directly upstream of the parity checker and presents `dout`, the parity bit on `rxin`, and a one-cycle `load` strobe in the form that stage consumes.

## Interface
- `OVERSAMPLE`, default 16: `baud_tick` pulses per bit period. Must be an even number, at least 4.
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset. One clock domain; polarity and synchronicity are fixed.
- `baud_tick` input 1: single-`clk` enable at OVERSAMPLE × baud rate, from the baud generator.
- `rx` input 1: asynchronous serial line. Idles high.
- `dout` output 8: received data byte, bit 0 = first data bit on the line.
- `rxin` output 1: received parity bit, paired with `dout`.
- `load` output 1: one-`clk` pulse; `dout`/`rxin` hold a new, stop-valid frame.
- `framing_error` output 1: one-`clk` pulse when a sampled stop bit is 0.
- `busy` output 1: high in every state except IDLE.

## Operation
- Frame format: 1 start bit (0), 8 data bits (LSB first), 1 parity bit (even parity: parity bit = XOR of the data bits), 1 stop bit (1).
- This block does not judge parity. It forwards the parity bit on `rxin` unchanged.
- `rx` passes through a 2-flop synchronizer. All FSM decisions use the synchronized value `rx_s`.
- Tick counter `tcnt`, width clog2(OVERSAMPLE), advances only on `baud_tick`.
- Bit counter `bcnt` runs 0..7 in DATA.
- FSM states and transitions:
  - IDLE: on a `baud_tick` with `rx_s`=0, set `tcnt`=0 and go to START.
  - START: at `tcnt`=OVERSAMPLE/2-1, sample `rx_s`. If 0, clear `tcnt` and go to DATA with `bcnt`=0. If 1 (glitch), go to IDLE with no outputs.
  - DATA: each time `tcnt` wraps at OVERSAMPLE-1, sample `rx_s` into shift register bit 7 and shift right. After `bcnt`=7, go to PARITY.
  - PARITY: at the wrap, sample into `par_r`, then go to STOP.
  - STOP: at the wrap, sample `rx_s`.
    - If 1: copy the shift register to `dout` and `par_r` to `rxin`, pulse `load`, go to IDLE.
    - If 0: pulse `framing_error`; `dout`/`rxin` keep their previous values; go to BREAK.
  - BREAK: wait for `rx_s`=1 (checked on any `clk`), then go to IDLE.
- Reset values: `dout`=8'h00, `rxin`=0, `load`=0, `framing_error`=0, `busy`=0, state IDLE, both counters 0, synchronizer flops 1.
- Reset asserted mid-frame: the partial frame is discarded, with no `load` or `framing_error`.
- `load` and `framing_error` are never high in the same cycle.

## Timing
- Synchronizer latency: 2 `clk`.
- Start is confirmed OVERSAMPLE/2 ticks after the detecting tick. Each later sample is exactly OVERSAMPLE ticks after the previous one, so it lands at mid-bit.
- `load` / `framing_error` go high on the `clk` edge that follows the `baud_tick` cycle of the stop sample. They stay high for exactly one `clk`.
- `dout` and `rxin` change on the same edge `load` rises. They are stable during the `load` cycle and until the next `load`.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge arriving half a bit later is caught. There is no minimum idle gap.
- `baud_tick` high on every `clk` is legal.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP, BREAK)
  - `UART_DATA_BITS`=8
  - `UART_OVERSAMPLE_DEFAULT`=16
  - idle line level constant
- Sub-module `uart_rx_sync`: the 2-flop synchronizer, with the same asynchronous active-low reset preset to 1.
- The FSM, counters and shift register live in the top module.

## Test plan
Common setup: OVERSAMPLE=16, `baud_tick` every 4 `clk` (64 `clk` per bit).
1. Send 0x55, parity 0, stop 1 → one `load` pulse; `dout`=0x55, `rxin`=0, `framing_error`=0. `busy` falls after the stop sample.
2. Send 0xA7 with parity 1, then 0xA7 with wrong parity 0:
   - first frame → `dout`=0xA7, `rxin`=1
   - second frame → `load` still pulses, `dout`=0xA7, `rxin`=0
   - downstream parity check flags the second frame.
3. Pull `rx` low for 3 ticks, then high → return to IDLE after the START sample; no `load`, no `framing_error`.
4. Send 0x3C with stop bit 0 after a good 0x55:
   - `framing_error` pulses once; no `load`; `dout` stays 0x55.
   - `busy` stays high in BREAK until `rx`=1.
   - A following 0x12 frame is then received correctly.
5. Assert `reset` during data bit 4 of a frame → all outputs at reset values within the same `clk`. After release and line idle, 0x81 is received with `dout`=0x81, `rxin`=0.
6. Send 0x00 then 0xFF with no idle gap, correct parity each → two `load` pulses 176 ticks (704 `clk`) apart, `dout`=0x00 then 0xFF.
